whack_game_ctrl: RTL and testbench
==================================

Name: whack_game_ctrl

Overview:
- Parametrised game sequencer for the whack-a-mole design: pre-game countdown, timed play round, score keeping and end-of-game hold, all in one FSM.
- Generalises the current fixed 5-button / 5 s / 30 s datapath to N moles, configurable countdown and round lengths, mole lifetime, miss-penalty mode and a best-score register.
- Sits between the button debouncers, the 1 Hz and 1 kHz tick generators, the LED bank and display_control; its 32-bit display word feeds display_control directly.

Parameters:
- N_MOLES, 5, number of mole LEDs/buttons (2..16)
- COUNTDOWN_S, 5, pre-game countdown length in seconds (1..15)
- GAME_S, 30, play-round length in seconds (1..99)
- MOLE_LIFE_MS, 800, mole visible time in ms ticks (1..4095)
- SCORE_W, 8, score register width
- PENALTY_EN, 0, 1 = a wrong or empty press subtracts 1 point (floor 0)
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-clk-wide 1 Hz enable pulse
- tick_1khz  in  1  one-clk-wide 1 kHz enable pulse
- start  in  1  debounced start request, level
- button_in  in  N_MOLES  debounced mole buttons, level, bit i = mole i
- mole_led  out  N_MOLES  one-hot lit mole, 0 when none
- display_value  out  32  value for display_control
- score  out  SCORE_W  current score
- best_score  out  SCORE_W  highest completed-game score
- state_o  out  2  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 OVER
- game_active  out  1  high in PLAY only

Behaviour:
- Reset (reset=0, asynchronous) sets state IDLE, mole_led=0, score=0, best_score=0, display_value=0, timers=0, LFSR=LFSR_SEED. Reset mid-game aborts immediately with no best_score update.
- All inputs are sampled on the rising edge of clk. Rising edges of start and button_in are detected internally with a one-cycle registered history. Only edges count as presses; a held button never scores twice.
- IDLE:
  - display_value = best_score, zero-extended.
  - A rising edge of start loads the second counter with COUNTDOWN_S, clears score and enters COUNTDOWN.
- COUNTDOWN:
  - display_value = remaining seconds; mole_led = 0.
  - Each tick_1hz decrements the counter.
  - On the tick that takes the counter from 1 to 0, load GAME_S, spawn the first mole and enter PLAY on the next clk.
- PLAY:
  - display_value = score.
  - Spawn: the LFSR (16-bit Fibonacci, taps 16,14,13,11) advances every clk. At spawn, index = LFSR mod N_MOLES. If index equals the previous mole, use index+1 mod N_MOLES. Load the life counter with MOLE_LIFE_MS.
  - Hit: a press edge on the lit bit gives score+1, saturating at 2^SCORE_W-1. It also respawns a mole in the same cycle.
  - Miss: an edge on any unlit bit, with PENALTY_EN=1, gives score-1 with a floor of 0. With PENALTY_EN=0 it has no effect.
  - Simultaneous edges in one cycle: if the lit bit is among them, the hit is counted and no penalty applies. Otherwise at most one penalty is applied per cycle.
  - Timeout: tick_1khz decrements the life counter. On reaching 0 the mole respawns with no score change.
  - Round end: tick_1hz decrements the round counter. On 1 to 0, enter OVER and clear mole_led.
  - A press in the same clk as the final second tick is still scored.
- OVER:
  - best_score is updated to score if score > best_score, exactly once on entry.
  - display_value = score. mole_led = all-ones blinking at 1 Hz (toggles each tick_1hz).
  - A start edge gives a new COUNTDOWN with score cleared.
- Latency: button edge to score/display update is 2 clk (1 edge register + 1 score register). mole_led changes 1 clk after the spawn decision.
- tick_1hz and tick_1khz arriving in the same clk are both honoured.
- A start edge during COUNTDOWN or PLAY is ignored.

Decomposition:
- Shared package whack_pkg holds the state encoding constants (ST_IDLE..ST_OVER), the LFSR taps and the default timing constants.
- One sub-module is natural: mole_picker. It contains the LFSR, the modulo-N index, the no-repeat rule and the one-hot encode. Inputs are clk, reset, spawn; output is mole_onehot.
- The FSM, timers and score stay in whack_game_ctrl.

Test Plan:
- Reset, then start pulse, then 5 tick_1hz pulses -> display_value 5,4,3,2,1, then state_o=2 with exactly one mole_led bit set.
- PLAY, press the lit button 3 times (press/release) -> score=3, display_value=3; each press moves the mole to a different bit.
- PLAY, hold the lit button for 1000 clk -> score increments by exactly 1.
- PENALTY_EN=1, score=2, press 3 unlit buttons in separate cycles -> score 1,0,0. The same cycle with lit+unlit pressed -> +1 only.
- No presses, 800 tick_1khz pulses -> mole respawns at a different index, score unchanged.
- Finish a game with score 4 (best 0), then a game with score 2 -> best_score 4; IDLE display shows 4. Asserting reset mid-PLAY -> all outputs 0, state_o=0.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared state encoding, LFSR taps and default timing for the whack-a-mole game controller.
package whack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_PLAY      = 2'd2,
      ST_OVER      = 2'd3
   } state_t;

   // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int unsigned DEF_N_MOLES      = 5;
   localparam int unsigned DEF_COUNTDOWN_S  = 5;
   localparam int unsigned DEF_GAME_S       = 30;
   localparam int unsigned DEF_MOLE_LIFE_MS = 800;
   localparam int unsigned DEF_SCORE_W      = 8;
   localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;

endpackage

// File: rtl/whack_game_ctrl_mole_picker.sv
// Pseudo-random mole selector: free-running LFSR, modulo-N index, no immediate repeat.
module mole_picker
   import whack_pkg::*;
#(
   parameter int unsigned N_MOLES   = DEF_N_MOLES,
   parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               spawn,
   output logic [N_MOLES-1:0] mole_onehot
);

   localparam logic [N_MOLES-1:0] ONE = N_MOLES'(1);

   logic [15:0]        lfsr;
   logic [N_MOLES-1:0] cand;

   // Rotating the one-hot left by one is the "index+1 mod N" retry when the draw repeats.
   always_comb begin
      cand = ONE << (lfsr % 16'(N_MOLES));
      if (|(cand & mole_onehot)) begin
         cand = {cand[N_MOLES-2:0], cand[N_MOLES-1]};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr        <= LFSR_SEED;
         mole_onehot <= '0;
      end else begin
         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
         if (spawn) begin
            mole_onehot <= cand;
         end
      end
   end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: countdown, timed round, scoring, best score and end-of-game blink.
module whack_game_ctrl
   import whack_pkg::*;
#(
   parameter int unsigned N_MOLES      = DEF_N_MOLES,
   parameter int unsigned COUNTDOWN_S  = DEF_COUNTDOWN_S,
   parameter int unsigned GAME_S       = DEF_GAME_S,
   parameter int unsigned MOLE_LIFE_MS = DEF_MOLE_LIFE_MS,
   parameter int unsigned SCORE_W      = DEF_SCORE_W,
   parameter bit          PENALTY_EN   = 1'b0,
   parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick_1hz,
   input  logic               tick_1khz,
   input  logic               start,
   input  logic [N_MOLES-1:0] button_in,
   output logic [N_MOLES-1:0] mole_led,
   output logic [31:0]        display_value,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] best_score,
   output logic [1:0]         state_o,
   output logic               game_active
);

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t             state, state_n;
   logic [6:0]         sec_cnt, sec_n;
   logic [11:0]        life_cnt, life_n;
   logic [SCORE_W-1:0] score_n, best_n;
   logic               blink, blink_n;
   logic               spawn, hit, miss;
   logic               start_prev, start_edge;
   logic [N_MOLES-1:0] btn_prev, btn_edge, mole_onehot;

   mole_picker #(
      .N_MOLES   (N_MOLES),
      .LFSR_SEED (LFSR_SEED)
   ) u_picker (
      .clk         (clk),
      .reset       (reset),
      .spawn       (spawn),
      .mole_onehot (mole_onehot)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      sec_n   = sec_cnt;
      life_n  = life_cnt;
      score_n = score;
      best_n  = best_score;
      blink_n = blink;
      spawn   = 1'b0;
      hit     = |(btn_edge & mole_onehot);
      miss    = |(btn_edge & ~mole_onehot);
      unique case (state)
         ST_IDLE: begin
            if (start_edge) begin
               sec_n   = 7'(COUNTDOWN_S);
               score_n = '0;
               state_n = ST_COUNTDOWN;
            end
         end
         ST_COUNTDOWN: begin
            if (tick_1hz) begin
               if (sec_cnt == 7'd1) begin
                  sec_n   = 7'(GAME_S);
                  life_n  = 12'(MOLE_LIFE_MS);
                  spawn   = 1'b1;
                  state_n = ST_PLAY;
               end else begin
                  sec_n = sec_cnt - 7'd1;
               end
            end
         end
         ST_PLAY: begin
            if (hit) begin
               if (score != SCORE_MAX) score_n = score + SCORE_W'(1);
               spawn  = 1'b1;
               life_n = 12'(MOLE_LIFE_MS);
            end else begin
               if (PENALTY_EN && miss && score != '0) score_n = score - SCORE_W'(1);
               if (tick_1khz) begin
                  if (life_cnt == 12'd1) begin
                     spawn  = 1'b1;
                     life_n = 12'(MOLE_LIFE_MS);
                  end else begin
                     life_n = life_cnt - 12'd1;
                  end
               end
            end
            // The last-second press is already folded into score_n before best is compared.
            if (tick_1hz) begin
               if (sec_cnt == 7'd1) begin
                  state_n = ST_OVER;
                  blink_n = 1'b0;
                  if (score_n > best_score) best_n = score_n;
               end else begin
                  sec_n = sec_cnt - 7'd1;
               end
            end
         end
         ST_OVER: begin
            if (tick_1hz) blink_n = ~blink;
            if (start_edge) begin
               sec_n   = 7'(COUNTDOWN_S);
               score_n = '0;
               state_n = ST_COUNTDOWN;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         sec_cnt    <= '0;
         life_cnt   <= '0;
         score      <= '0;
         best_score <= '0;
         blink      <= 1'b0;
         start_prev <= 1'b0;
         start_edge <= 1'b0;
         btn_prev   <= '0;
         btn_edge   <= '0;
      end else begin
         state      <= state_n;
         sec_cnt    <= sec_n;
         life_cnt   <= life_n;
         score      <= score_n;
         best_score <= best_n;
         blink      <= blink_n;
         start_prev <= start;
         start_edge <= start & ~start_prev;
         btn_prev   <= button_in;
         btn_edge   <= button_in & ~btn_prev;
      end
   end

   always_comb begin
      mole_led      = '0;
      display_value = 32'(score);
      unique case (state)
         ST_IDLE:      display_value = 32'(best_score);
         ST_COUNTDOWN: display_value = 32'(sec_cnt);
         ST_PLAY:      mole_led = mole_onehot;
         ST_OVER:      mole_led = blink ? '1 : '0;
         default:      mole_led = '0;
      endcase
   end

   assign state_o     = state;
   assign game_active = (state == ST_PLAY);

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Randomized and directed bench for whack_game_ctrl against a behavioural game model.
module tb_whack_game_ctrl;

   localparam int N    = 5;
   localparam int CD_S = 5;
   localparam int GAME = 30;
   localparam int LIFE = 800;
   localparam int SW   = 4;
   localparam int MAXS = (1 << SW) - 1;
   localparam int ALL  = (1 << N) - 1;
   localparam int SEED = 16'hACE1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          tick_1hz = 1'b0;
   logic          tick_1khz = 1'b0;
   logic          start = 1'b0;
   logic [N-1:0]  button_in = '0;
   logic [N-1:0]  mole_led;
   logic [31:0]   display_value;
   logic [SW-1:0] score;
   logic [SW-1:0] best_score;
   logic [1:0]    state_o;
   logic          game_active;

   int n_vec = 0;
   int n_err = 0;

   whack_game_ctrl #(
      .N_MOLES      (N),
      .COUNTDOWN_S  (CD_S),
      .GAME_S       (GAME),
      .MOLE_LIFE_MS (LIFE),
      .SCORE_W      (SW),
      .PENALTY_EN   (1'b1),
      .LFSR_SEED    (16'hACE1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tick_1hz      (tick_1hz),
      .tick_1khz     (tick_1khz),
      .start         (start),
      .button_in     (button_in),
      .mole_led      (mole_led),
      .display_value (display_value),
      .score         (score),
      .best_score    (best_score),
      .state_o       (state_o),
      .game_active   (game_active)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got %0d vectors expected completion", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Game model: phases 0 idle, 1 countdown, 2 play, 3 over; presses act one clock after their edge.
   int m_state, m_sec, m_life, m_score, m_best, m_idx, m_lfsr;
   bit m_blink;
   int m_start_prev, m_start_pend, m_btn_prev, m_btn_pend;

   function automatic int lfsr_next(int v);
      int fb;
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
      return ((v << 1) | fb) & 16'hFFFF;
   endfunction

   task automatic model_reset();
      m_state = 0; m_sec = 0; m_life = 0; m_score = 0; m_best = 0;
      m_idx = -1; m_lfsr = SEED; m_blink = 0;
      m_start_prev = 0; m_start_pend = 0; m_btn_prev = 0; m_btn_pend = 0;
   endtask

   task automatic model_spawn();
      int idx;
      idx = m_lfsr % N;
      if (idx == m_idx) idx = (idx + 1) % N;
      m_idx = idx;
   endtask

   task automatic model_clock(int st, int btn, bit t1, bit t1k);
      int hit, others;
      case (m_state)
         0: if (m_start_pend != 0) begin m_sec = CD_S; m_score = 0; m_state = 1; end
         1: if (t1) begin
               m_sec--;
               if (m_sec == 0) begin m_sec = GAME; m_life = LIFE; model_spawn(); m_state = 2; end
            end
         2: begin
               hit    = (m_btn_pend >> m_idx) & 1;
               others = m_btn_pend & ~(1 << m_idx);
               if (hit != 0) begin
                  if (m_score < MAXS) m_score++;
                  model_spawn();
                  m_life = LIFE;
               end else begin
                  if (others != 0 && m_score > 0) m_score--;
                  if (t1k) begin
                     m_life--;
                     if (m_life == 0) begin model_spawn(); m_life = LIFE; end
                  end
               end
               if (t1) begin
                  m_sec--;
                  if (m_sec == 0) begin
                     m_state = 3; m_blink = 0;
                     if (m_score > m_best) m_best = m_score;
                  end
               end
            end
         default: begin
               if (t1) m_blink = !m_blink;
               if (m_start_pend != 0) begin m_sec = CD_S; m_score = 0; m_state = 1; end
            end
      endcase
      m_lfsr       = lfsr_next(m_lfsr);
      m_start_pend = st & ~m_start_prev;
      m_start_prev = st;
      m_btn_pend   = btn & ~m_btn_prev & ALL;
      m_btn_prev   = btn;
   endtask

   task automatic compare_all();
      int exp_led, exp_disp;
      exp_led = 0;
      if (m_state == 2) exp_led = 1 << m_idx;
      else if (m_state == 3 && m_blink) exp_led = ALL;
      exp_disp = (m_state == 0) ? m_best : (m_state == 1) ? m_sec : m_score;
      check("state", 32'(state_o), m_state);
      check("mole_led", 32'(mole_led), exp_led);
      check("display", display_value, exp_disp);
      check("score", 32'(score), m_score);
      check("best", 32'(best_score), m_best);
      check("active", 32'(game_active), (m_state == 2) ? 1 : 0);
      if (m_state == 2) check("onehot", $countones(mole_led), 1);
   endtask

   task automatic step(bit st, logic [N-1:0] btn, bit t1, bit t1k);
      start = st; button_in = btn; tick_1hz = t1; tick_1khz = t1k;
      model_clock(int'(st), int'(btn), t1, t1k);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic [N-1:0] lit_mask();
      return N'(1) << m_idx;
   endfunction

   function automatic logic [N-1:0] unlit_mask();
      return N'(1) << ((m_idx + 1) % N);
   endfunction

   task automatic press(logic [N-1:0] mask);
      step(1'b0, mask, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic apply_reset();
      start = 1'b0; button_in = '0; tick_1hz = 1'b0; tick_1khz = 1'b0;
      reset = 1'b0;
      #1;
      model_reset();
      check("rst_state", 32'(state_o), 0);
      check("rst_led", 32'(mole_led), 0);
      check("rst_disp", display_value, 0);
      check("rst_score", 32'(score), 0);
      check("rst_best", 32'(best_score), 0);
      check("rst_active", 32'(game_active), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic begin_game();
      step(1'b1, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      for (int k = CD_S; k >= 1; k--) begin
         check("cd_disp", display_value, k);
         step(1'b0, '0, 1'b1, 1'b0);
         step(1'b0, '0, 1'b0, 1'b0);
      end
      check("play_state", 32'(state_o), 2);
      check("play_onehot", $countones(mole_led), 1);
   endtask

   task automatic end_round();
      for (int k = 0; k < GAME; k++) step(1'b0, '0, 1'b1, 1'b0);
      check("over_state", 32'(state_o), 3);
   endtask

   initial begin
      logic [N-1:0] old_led;
      apply_reset();

      // game 1: countdown, three clean hits, a held button, penalties, timeout
      begin_game();
      for (int k = 1; k <= 3; k++) begin
         old_led = mole_led;
         press(lit_mask());
         check("hit_moves", 32'(mole_led != old_led), 1);
      end
      check("hit3_score", 32'(score), 3);
      check("hit3_disp", display_value, 3);

      old_led = lit_mask();
      for (int k = 0; k < 1000; k++) step(1'b0, old_led, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("hold_score", 32'(score), 4);

      press(unlit_mask());
      press(unlit_mask());
      check("pen_prep", 32'(score), 2);
      press(unlit_mask());
      check("pen_1", 32'(score), 1);
      press(unlit_mask());
      check("pen_0", 32'(score), 0);
      press(unlit_mask());
      check("pen_floor", 32'(score), 0);
      press(lit_mask() | unlit_mask());
      check("lit_unlit", 32'(score), 1);

      old_led = mole_led;
      for (int k = 0; k < LIFE - 1; k++) step(1'b0, '0, 1'b0, 1'b1);
      check("life_hold", 32'(mole_led), 32'(old_led));
      step(1'b0, '0, 1'b0, 1'b1);
      check("life_respawn", 32'(mole_led != old_led), 1);
      check("life_score", 32'(score), 1);

      for (int k = 0; k < 3; k++) press(lit_mask());
      end_round();
      check("g1_best", 32'(best_score), 4);
      check("g1_disp", display_value, 4);
      check("g1_led_off", 32'(mole_led), 0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("blink_on", 32'(mole_led), ALL);
      step(1'b0, '0, 1'b1, 1'b0);
      check("blink_off", 32'(mole_led), 0);

      // game 2: lower score keeps best
      begin_game();
      press(lit_mask());
      press(lit_mask());
      end_round();
      check("g2_score", 32'(score), 2);
      check("g2_best", 32'(best_score), 4);

      // game 3: saturation
      begin_game();
      for (int k = 0; k < MAXS + 2; k++) press(lit_mask());
      check("sat_score", 32'(score), MAXS);
      check("sat_disp", display_value, MAXS);
      end_round();
      check("sat_best", 32'(best_score), MAXS);

      // randomized play across several games
      for (int i = 0; i < 4000; i++) begin
         logic [N-1:0] b;
         int r;
         r = $urandom_range(0, 7);
         case (r)
            0:       b = lit_mask();
            1:       b = N'($urandom);
            2:       b = lit_mask() | N'($urandom);
            default: b = '0;
         endcase
         step($urandom_range(0, 199) == 0, b, $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
      end

      // reset in the middle of a round
      apply_reset();
      begin_game();
      press(lit_mask());
      apply_reset();
      for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b1);
      check("post_rst_idle", 32'(state_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
